// File: rtl/program_loader.sv
// Streams a word-count header plus MSB-first instruction bytes into the instruction RAM
// from BASE_ADDR upward, holding the CPU off while a load is in progress or has failed.
module program_loader #(
  parameter int unsigned ADDRESS_BUS_WIDTH = 10,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned BASE_ADDR         = 512,
  parameter int unsigned WORD_STEP         = 4,
  parameter int unsigned MAX_WORDS         = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  output logic [ADDRESS_BUS_WIDTH-1:0] imem_address,
  output logic [INSTRUCTION_WIDTH-1:0] imem_write_data,
  output logic                         imem_write,
  output logic                         cpu_hold,
  output logic                         load_done,
  output logic                         load_error,
  output logic [7:0]                   words_written
);

  localparam int unsigned BytesPerWord = INSTRUCTION_WIDTH / 8;
  localparam int unsigned CntW = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam logic [CntW-1:0] LastByte = CntW'(BytesPerWord - 1);
  localparam logic [ADDRESS_BUS_WIDTH-1:0] BaseAddr = ADDRESS_BUS_WIDTH'(BASE_ADDR);
  localparam logic [ADDRESS_BUS_WIDTH-1:0] AddrStep = ADDRESS_BUS_WIDTH'(WORD_STEP);

  typedef enum logic [2:0] {
    StIdle,
    StHdrHi,
    StHdrLo,
    StCollect,
    StWrite,
    StDone,
    StError
  } state_e;

  state_e                         state_q, state_d;
  logic [15:0]                    count_q, count_d;
  logic [CntW-1:0]                byte_cnt_q, byte_cnt_d;
  logic [INSTRUCTION_WIDTH-1:0]   word_q, word_d;
  logic [INSTRUCTION_WIDTH-1:0]   data_q, data_d;
  logic [ADDRESS_BUS_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                     ww_q, ww_d;

  logic                           xfer;
  logic                           start;
  logic [15:0]                    hdr_count;
  logic [INSTRUCTION_WIDTH-1:0]   word_shifted;
  logic                           last_word;

  assign xfer         = byte_valid & byte_ready;
  assign start        = load_start &
                        ((state_q == StIdle) | (state_q == StDone) | (state_q == StError));
  assign hdr_count    = {count_q[15:8], byte_in};
  assign word_shifted = (word_q << 8) | INSTRUCTION_WIDTH'(byte_in);
  assign last_word    = ({8'd0, ww_q + 8'd1} == count_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (load_start) state_d = StHdrHi;
      end
      StHdrHi: begin
        if (xfer) state_d = StHdrLo;
      end
      StHdrLo: begin
        if (xfer) begin
          if (hdr_count == 16'd0) begin
            state_d = StDone;
          end else if ({16'd0, hdr_count} > MAX_WORDS) begin
            state_d = StError;
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (xfer && (byte_cnt_q == LastByte)) state_d = StWrite;
      end
      StWrite: begin
        state_d = last_word ? StDone : StCollect;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode; every status output is a pure function of state.
  always_comb begin
    byte_ready = 1'b0;
    imem_write = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    unique case (state_q)
      StIdle: ;
      StHdrHi, StHdrLo, StCollect: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
      end
      StWrite: begin
        imem_write = 1'b1;
        cpu_hold   = 1'b1;
      end
      StDone: load_done = 1'b1;
      StError: begin
        cpu_hold   = 1'b1;
        load_error = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    data_d     = data_q;
    addr_d     = addr_q;
    ww_d       = ww_q;
    if (start) begin
      ww_d   = 8'd0;
      addr_d = BaseAddr;
    end
    unique case (state_q)
      StHdrHi: begin
        if (xfer) count_d[15:8] = byte_in;
      end
      StHdrLo: begin
        if (xfer) begin
          count_d[7:0] = byte_in;
          byte_cnt_d   = '0;
        end
      end
      StCollect: begin
        if (xfer) begin
          word_d     = word_shifted;
          byte_cnt_d = byte_cnt_q + 1'b1;
          // Latch the finished word so the RAM sees a stable value in the write cycle.
          if (byte_cnt_q == LastByte) begin
            data_d     = word_shifted;
            byte_cnt_d = '0;
          end
        end
      end
      StWrite: begin
        ww_d   = ww_q + 8'd1;
        addr_d = addr_q + AddrStep;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= 16'd0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      data_q     <= '0;
      addr_q     <= BaseAddr;
      ww_q       <= 8'd0;
    end else begin
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      ww_q       <= ww_d;
    end
  end

  assign imem_address    = addr_q;
  assign imem_write_data = data_q;
  assign words_written   = ww_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: stimulus queues expected RAM writes,
// a monitor pops and compares on every write strobe.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [9:0]  imem_address;
  logic [31:0] imem_write_data;
  logic        imem_write;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [7:0]  words_written;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  logic [9:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  program_loader dut (
    .clk             (clk),
    .reset           (reset),
    .load_start      (load_start),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .imem_address    (imem_address),
    .imem_write_data (imem_write_data),
    .imem_write      (imem_write),
    .cpu_hold        (cpu_hold),
    .load_done       (load_done),
    .load_error      (load_error),
    .words_written   (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset && imem_write === 1'b1) begin
      wr_count++;
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", {22'd0, imem_address}, 32'h3ff);
      end else begin
        check("wr_addr", {22'd0, imem_address}, {22'd0, exp_addr_q.pop_front()});
        check("wr_data", imem_write_data, exp_data_q.pop_front());
        check("ready_in_write", {31'd0, byte_ready}, 32'd0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Offer a byte and return at the negedge just after it transfers; valid stays high.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    budget     = 0;
    while (byte_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_header(input logic [15:0] cnt);
    send_byte(cnt[15:8], 1'b0);
    send_byte(cnt[7:0], 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input bit gaps);
    exp_addr_q.push_back(10'(512 + 4 * idx));
    exp_data_q.push_back(w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic wait_finish();
    int budget;
    byte_valid = 1'b0;
    budget = 0;
    while (load_done !== 1'b1 && load_error !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) check("finish_timeout", {31'd0, load_done}, 32'd1);
  endtask

  initial begin
    int wr_snap;
    reset      = 1'b0;
    load_start = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #12;
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_addr", {22'd0, imem_address}, 32'd512);
    check("rst_data", imem_write_data, 32'd0);
    check("rst_ww", {24'd0, words_written}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single word, continuous valid
    pulse_start();
    check("start_hold", {31'd0, cpu_hold}, 32'd1);
    check("start_ready", {31'd0, byte_ready}, 32'd1);
    send_header(16'd1);
    send_word(32'hDEADBEEF, 0, 1'b0);
    check("strobe_latency", {31'd0, imem_write}, 32'd1);
    wait_finish();
    check("w1_done", {31'd0, load_done}, 32'd1);
    check("w1_hold", {31'd0, cpu_hold}, 32'd0);
    check("w1_ww", {24'd0, words_written}, 32'd1);
    check("w1_addr_after", {22'd0, imem_address}, 32'd516);
    check("w1_data_hold", imem_write_data, 32'hDEADBEEF);

    // Three words with random valid gaps
    pulse_start();
    check("w3_done_clr", {31'd0, load_done}, 32'd0);
    check("w3_addr_base", {22'd0, imem_address}, 32'd512);
    send_header(16'd3);
    send_word(32'h11111111, 0, 1'b1);
    send_word(32'h22222222, 1, 1'b1);
    send_word(32'h33333333, 2, 1'b1);
    wait_finish();
    check("w3_done", {31'd0, load_done}, 32'd1);
    check("w3_ww", {24'd0, words_written}, 32'd3);

    // Zero count
    wr_snap = wr_count;
    pulse_start();
    send_header(16'd0);
    check("zero_done", {31'd0, load_done}, 32'd1);
    check("zero_ww", {24'd0, words_written}, 32'd0);
    repeat (3) @(negedge clk);
    check("zero_nowrite", wr_count, wr_snap);

    // Overflow then recovery
    wr_snap = wr_count;
    pulse_start();
    send_header(16'h0081);
    byte_valid = 1'b0;
    check("ovf_error", {31'd0, load_error}, 32'd1);
    check("ovf_hold", {31'd0, cpu_hold}, 32'd1);
    check("ovf_ready", {31'd0, byte_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("ovf_nowrite", wr_count, wr_snap);
    pulse_start();
    check("ovf_err_clr", {31'd0, load_error}, 32'd0);
    send_header(16'd2);
    send_word(32'hCAFEF00D, 0, 1'b0);
    send_word(32'h01234567, 1, 1'b0);
    wait_finish();
    check("rec_done", {31'd0, load_done}, 32'd1);
    check("rec_ww", {24'd0, words_written}, 32'd2);

    // Reset mid-stream
    pulse_start();
    send_header(16'd2);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    byte_valid = 1'b0;
    wr_snap = wr_count;
    #2 reset = 1'b0;
    #1;
    check("mrst_ready", {31'd0, byte_ready}, 32'd0);
    check("mrst_hold", {31'd0, cpu_hold}, 32'd0);
    check("mrst_done", {31'd0, load_done}, 32'd0);
    check("mrst_ww", {24'd0, words_written}, 32'd0);
    check("mrst_addr", {22'd0, imem_address}, 32'd512);
    check("mrst_data", imem_write_data, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_nowrite", wr_count, wr_snap);
    pulse_start();
    send_header(16'd1);
    send_word(32'h0BADF00D, 0, 1'b0);
    wait_finish();
    check("mrst_reload_ww", {24'd0, words_written}, 32'd1);

    // Full capacity, with an ignored load_start during COLLECT
    pulse_start();
    send_header(16'd128);
    exp_addr_q.push_back(10'd512);
    exp_data_q.push_back(32'hC0DE0000);
    send_byte(8'hC0, 1'b0);
    send_byte(8'hDE, 1'b0);
    byte_valid = 1'b0;
    pulse_start();
    check("cap_ignore_ready", {31'd0, byte_ready}, 32'd1);
    check("cap_ignore_hold", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 1; i < 128; i++) send_word(32'hC0DE0000 + 32'(i), i, 1'b0);
    wait_finish();
    check("cap_done", {31'd0, load_done}, 32'd1);
    check("cap_ww", {24'd0, words_written}, 32'd128);
    check("cap_last_data", imem_write_data, 32'hC0DE007F);

    // Restart from DONE
    pulse_start();
    check("rs_done_clr", {31'd0, load_done}, 32'd0);
    check("rs_ww_clr", {24'd0, words_written}, 32'd0);
    check("rs_addr", {22'd0, imem_address}, 32'd512);
    send_header(16'd1);
    send_word(32'hFEEDFACE, 0, 1'b0);
    wait_finish();
    check("rs_done", {31'd0, load_done}, 32'd1);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_addr_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
